// File: rtl/tx_lane_scheduler_if.sv
// Lane-side bus of the tx_lane_scheduler.
// Carries the four lane write ports and rx_sync into the scheduler, and the
// serializer byte path, per-lane flow-control flags and link state out of it.
//   master : the lane sources / link monitor (drives lane bytes and rx_sync)
//   slave  : the scheduler itself
interface tx_lane_scheduler_if;
  logic [7:0] data_in_0;
  logic [7:0] data_in_1;
  logic [7:0] data_in_2;
  logic [7:0] data_in_3;
  logic       valid_in_0;
  logic       valid_in_1;
  logic       valid_in_2;
  logic       valid_in_3;
  logic       rx_sync;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] lane_sel;
  logic       pause_0;
  logic       pause_1;
  logic       pause_2;
  logic       pause_3;
  logic       overflow_0;
  logic       overflow_1;
  logic       overflow_2;
  logic       overflow_3;
  logic [1:0] state;

  modport master (
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3,
    output rx_sync,
    input  data_out, valid_out, lane_sel,
    input  pause_0, pause_1, pause_2, pause_3,
    input  overflow_0, overflow_1, overflow_2, overflow_3,
    input  state
  );

  modport slave (
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  valid_in_0, valid_in_1, valid_in_2, valid_in_3,
    input  rx_sync,
    output data_out, valid_out, lane_sel,
    output pause_0, pause_1, pause_2, pause_3,
    output overflow_0, overflow_1, overflow_2, overflow_3,
    output state
  );
endinterface

// File: rtl/tx_lane_scheduler.sv
// tx_lane_scheduler: buffers four byte lanes in per-lane FIFOs and shares the
// single byte path into the serializer round-robin, one byte per clock, while
// the link is ACTIVE. COM is sent as filler whenever no lane is granted.
// Ports:
//   clk_4f   sole clock, posedge
//   reset_L  asynchronous active-low reset
//   bus      tx_lane_scheduler_if.slave (lane writes, rx_sync, data_out,
//            valid_out, lane_sel, pause_x, overflow_x, state)
//
// state      | meaning
// -----------+--------------------------------------------------------
// RESET  00  | one cycle after reset release; lane writes ignored
// WAIT_SYNC 01| counting consecutive rx_sync cycles; lanes buffer only
// ACTIVE 10  | link up; round-robin grant of one byte per clock
// (11)       | unused; recovers to RESET
module tx_lane_scheduler #(
  parameter int         DEPTH    = 4,
  parameter int         PTR_W    = 2,
  parameter int         AFULL_TH = 3,
  parameter int         SYNC_CNT = 4,
  parameter logic [7:0] COM      = 8'hBC
) (
  input logic              clk_4f,
  input logic              reset_L,
  tx_lane_scheduler_if.slave bus
);

  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(SYNC_CNT + 1);

  typedef enum logic [1:0] {
    ST_RESET     = 2'b00,
    ST_WAIT_SYNC = 2'b01,
    ST_ACTIVE    = 2'b10,
    ST_UNUSED    = 2'b11
  } state_t;

  state_t            state_r, state_nxt;
  logic [SC_W-1:0]   sync_cnt, sync_cnt_nxt;

  logic [7:0]        din [4];
  logic [3:0]        vin;
  logic [7:0]        mem [4][DEPTH];
  logic [PTR_W-1:0]  wr_ptr [4];
  logic [PTR_W-1:0]  rd_ptr [4];
  logic [CNT_W-1:0]  count [4];
  logic [3:0]        overflow;
  logic [3:0]        nonempty;
  logic [3:0]        pause;
  logic [3:0]        push, pop, accept, drop;

  logic              wr_en;
  logic              grant_en;
  logic              grant_vld;
  logic [1:0]        grant_lane;
  logic [1:0]        cand;
  logic [7:0]        grant_byte;
  logic [1:0]        last_grant;

  logic [7:0]        data_out_r;
  logic              valid_out_r;
  logic [1:0]        lane_sel_r;

  assign din[0] = bus.data_in_0;
  assign din[1] = bus.data_in_1;
  assign din[2] = bus.data_in_2;
  assign din[3] = bus.data_in_3;
  assign vin    = {bus.valid_in_3, bus.valid_in_2, bus.valid_in_1, bus.valid_in_0};

  // ---------------- link FSM ----------------
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_r  <= ST_RESET;
      sync_cnt <= '0;
    end else begin
      state_r  <= state_nxt;
      sync_cnt <= sync_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_r;
    sync_cnt_nxt = sync_cnt;
    case (state_r)
      ST_RESET: begin
        state_nxt    = ST_WAIT_SYNC;
        sync_cnt_nxt = '0;
      end
      ST_WAIT_SYNC: begin
        if (!bus.rx_sync) begin
          sync_cnt_nxt = '0;
        end else if (sync_cnt == SC_W'(SYNC_CNT - 1)) begin
          state_nxt    = ST_ACTIVE;
          sync_cnt_nxt = '0;
        end else begin
          sync_cnt_nxt = sync_cnt + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!bus.rx_sync) begin
          state_nxt    = ST_WAIT_SYNC;
          sync_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = ST_RESET;
        sync_cnt_nxt = '0;
      end
    endcase
  end

  assign wr_en    = (state_r == ST_WAIT_SYNC) || (state_r == ST_ACTIVE);
  // Losing sync in ACTIVE suppresses the grant on that same edge.
  assign grant_en = (state_r == ST_ACTIVE) && bus.rx_sync;

  // ---------------- arbitration ----------------
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      nonempty[l] = (count[l] != '0);
      pause[l]    = (count[l] >= CNT_W'(AFULL_TH));
    end
  end

  // Search starts one past the last granted lane; i=4 wraps back onto it.
  always_comb begin
    grant_vld  = 1'b0;
    grant_lane = last_grant;
    cand       = last_grant;
    for (int i = 1; i <= 4; i++) begin
      cand = last_grant + 2'(i);
      if (grant_en && !grant_vld && nonempty[cand]) begin
        grant_vld  = 1'b1;
        grant_lane = cand;
      end
    end
  end

  assign grant_byte = mem[grant_lane][rd_ptr[grant_lane]];

  // A full lane still accepts a write when it is popped on the same edge.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      push[l]   = wr_en && vin[l];
      pop[l]    = grant_vld && (grant_lane == 2'(l));
      accept[l] = push[l] && ((count[l] != CNT_W'(DEPTH)) || pop[l]);
      drop[l]   = push[l] && (count[l] == CNT_W'(DEPTH)) && !pop[l];
    end
  end

  // ---------------- lane FIFOs ----------------
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < 4; l++) begin
        wr_ptr[l]   <= '0;
        rd_ptr[l]   <= '0;
        count[l]    <= '0;
        overflow[l] <= 1'b0;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (accept[l]) wr_ptr[l] <= wr_ptr[l] + 1'b1;
        if (pop[l])    rd_ptr[l] <= rd_ptr[l] + 1'b1;
        if (drop[l])   overflow[l] <= 1'b1;
        case ({accept[l], pop[l]})
          2'b10:   count[l] <= count[l] + 1'b1;
          2'b01:   count[l] <= count[l] - 1'b1;
          default: count[l] <= count[l];
        endcase
      end
    end
  end

  // Storage needs no reset: count/pointers define which entries are live.
  always_ff @(posedge clk_4f) begin
    for (int l = 0; l < 4; l++) begin
      if (accept[l]) mem[l][wr_ptr[l]] <= din[l];
    end
  end

  // ---------------- output register ----------------
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      data_out_r  <= COM;
      valid_out_r <= 1'b0;
      lane_sel_r  <= 2'd0;
      last_grant  <= 2'd3;
    end else if (grant_vld) begin
      data_out_r  <= grant_byte;
      valid_out_r <= 1'b1;
      lane_sel_r  <= grant_lane;
      last_grant  <= grant_lane;
    end else begin
      data_out_r  <= COM;
      valid_out_r <= 1'b0;
    end
  end

  assign bus.data_out   = data_out_r;
  assign bus.valid_out  = valid_out_r;
  assign bus.lane_sel   = lane_sel_r;
  assign bus.state      = state_r;
  assign bus.pause_0    = pause[0];
  assign bus.pause_1    = pause[1];
  assign bus.pause_2    = pause[2];
  assign bus.pause_3    = pause[3];
  assign bus.overflow_0 = overflow[0];
  assign bus.overflow_1 = overflow[1];
  assign bus.overflow_2 = overflow[2];
  assign bus.overflow_3 = overflow[3];

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler: reset values, sync sequencing,
// single-lane latency, round-robin drain, full/overflow boundaries,
// sync loss and asynchronous reset mid-stream.
module tb_tx_lane_scheduler;
  logic clk_4f;
  logic reset_L;
  int   total = 0;
  int   bad   = 0;

  tx_lane_scheduler_if bus();

  tx_lane_scheduler dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial begin
    clk_4f = 1'b0;
    forever #5 clk_4f = ~clk_4f;
  end

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_4f);
    #1;
  endtask

  task automatic set_lane(input int l, input logic [7:0] d, input logic v);
    case (l)
      0: begin bus.data_in_0 = d; bus.valid_in_0 = v; end
      1: begin bus.data_in_1 = d; bus.valid_in_1 = v; end
      2: begin bus.data_in_2 = d; bus.valid_in_2 = v; end
      default: begin bus.data_in_3 = d; bus.valid_in_3 = v; end
    endcase
  endtask

  task automatic idle_lanes();
    for (int l = 0; l < 4; l++) set_lane(l, 8'h00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, bus.state, 2'b00);
    check({tag, "_data"}, bus.data_out, 8'hBC);
    check({tag, "_valid"}, bus.valid_out, 1'b0);
    check({tag, "_lsel"}, bus.lane_sel, 2'd0);
    check({tag, "_pause"}, {bus.pause_3, bus.pause_2, bus.pause_1, bus.pause_0}, 4'h0);
    check({tag, "_ovf"}, {bus.overflow_3, bus.overflow_2, bus.overflow_1, bus.overflow_0}, 4'h0);
  endtask

  // Reset, release just after an edge, then one edge into WAIT_SYNC with rx_sync low.
  task automatic do_reset_to_wait();
    idle_lanes();
    bus.rx_sync = 1'b0;
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    tick();
    check("wait_entry", bus.state, 2'b01);
  endtask

  task automatic go_active();
    bit reached = 0;
    bus.rx_sync = 1'b1;
    for (int i = 0; i < 12 && !reached; i++) begin
      tick();
      if (bus.state == 2'b10) reached = 1;
    end
    check("sync_reach", bus.state, 2'b10);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic [1:0] ls);
    check({tag, "_data"}, bus.data_out, d);
    check({tag, "_valid"}, bus.valid_out, 1'b1);
    check({tag, "_lsel"}, bus.lane_sel, ls);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_data"}, bus.data_out, 8'hBC);
    check({tag, "_valid"}, bus.valid_out, 1'b0);
  endtask

  initial begin
    idle_lanes();
    bus.rx_sync = 1'b0;
    reset_L = 1'b0;
    #23;
    check_reset_outputs("rst0");

    // Sync sequencing: 00 -> 01 on first edge, 10 exactly four edges later.
    tick();
    reset_L = 1'b1;
    bus.rx_sync = 1'b1;
    tick();
    check("seq_s1", bus.state, 2'b01);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("seq_wait", bus.state, 2'b01);
      expect_idle("seq_wait");
    end
    tick();
    check("seq_active", bus.state, 2'b10);
    expect_idle("seq_active");

    // Single byte on lane 2: written at edge k, out after edge k+1.
    set_lane(2, 8'h11, 1'b1);
    tick();
    set_lane(2, 8'h00, 1'b0);
    expect_idle("lat_k");
    tick();
    expect_out("lat_k1", 8'h11, 2'd2);
    tick();
    expect_idle("lat_k2");
    check("lat_lsel_hold", bus.lane_sel, 2'd2);

    // Two bytes in every lane, drained strictly 0,1,2,3,0,1,2,3.
    do_reset_to_wait();
    for (int b = 0; b < 2; b++) begin
      for (int l = 0; l < 4; l++) set_lane(l, 8'(8'hA0 + 16 * l + b), 1'b1);
      tick();
    end
    idle_lanes();
    go_active();
    for (int i = 0; i < 8; i++) begin
      tick();
      expect_out("rr", 8'(8'hA0 + 16 * (i % 4) + i / 4), 2'(i % 4));
    end
    tick();
    expect_idle("rr_end");

    // Lane 1: write held through RESET (ignored), then 5 writes in WAIT_SYNC.
    idle_lanes();
    bus.rx_sync = 1'b0;
    reset_L = 1'b0;
    tick();
    reset_L = 1'b1;
    set_lane(1, 8'h4F, 1'b1);
    tick();
    check("rst_wr_state", bus.state, 2'b01);
    check("rst_wr_ignored", bus.pause_1, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      set_lane(1, 8'(8'h4F + n), 1'b1);
      tick();
      check("ovf_pause1", bus.pause_1, (n >= 3));
      check("ovf_flag1", bus.overflow_1, (n >= 5));
    end
    idle_lanes();
    go_active();
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out("ovf_drain", 8'(8'h50 + i), 2'd1);
    end
    tick();
    expect_idle("ovf_end");
    check("ovf_sticky", bus.overflow_1, 1'b1);

    // Lane 0 full, written on its grant cycle: no drop, count stays 4.
    do_reset_to_wait();
    for (int i = 0; i < 4; i++) begin
      set_lane(0, 8'(8'h60 + i), 1'b1);
      tick();
    end
    idle_lanes();
    check("full_pause0", bus.pause_0, 1'b1);
    go_active();
    set_lane(0, 8'h64, 1'b1);
    tick();
    idle_lanes();
    expect_out("full_rw", 8'h60, 2'd0);
    check("full_no_ovf", bus.overflow_0, 1'b0);
    check("full_pause_hold", bus.pause_0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_out("full_drain", 8'(8'h60 + i), 2'd0);
    end
    tick();
    expect_idle("full_end");
    check("full_pause_clr", bus.pause_0, 1'b0);

    // Sync loss with bytes pending on lane 3, then resume with nothing lost.
    do_reset_to_wait();
    for (int i = 0; i < 3; i++) begin
      set_lane(3, 8'(8'h70 + i), 1'b1);
      tick();
    end
    idle_lanes();
    go_active();
    tick();
    expect_out("loss_first", 8'h70, 2'd3);
    bus.rx_sync = 1'b0;
    tick();
    check("loss_state", bus.state, 2'b01);
    expect_idle("loss_idle");
    tick();
    expect_idle("loss_idle2");
    go_active();
    tick();
    expect_out("resume_1", 8'h71, 2'd3);
    tick();
    expect_out("resume_2", 8'h72, 2'd3);
    tick();
    expect_idle("resume_end");

    // Asynchronous reset mid-stream discards buffered bytes.
    set_lane(0, 8'h80, 1'b1);
    tick();
    set_lane(0, 8'h81, 1'b1);
    tick();
    idle_lanes();
    expect_out("mid_out", 8'h80, 2'd0);
    reset_L = 1'b0;
    #2;
    check_reset_outputs("mid_rst");
    tick();
    reset_L = 1'b1;
    bus.rx_sync = 1'b0;
    tick();
    check("mid_wait", bus.state, 2'b01);
    go_active();
    tick();
    expect_idle("mid_discard");
    tick();
    expect_idle("mid_discard2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_lane_scheduler.md
Name: tx_lane_scheduler

Overview:
Controller and arbiter in front of the phy_tx byte serializer. It buffers bytes from the four input lanes in per-lane FIFOs and shares the single byte path to the parallel-to-serial stage round-robin, one byte per clock. Scheduling is gated by a link state machine driven by the receive-side sync indication. When no byte is granted, it sends the COM symbol as filler.

Parameters:
DEPTH, 4, entries per lane FIFO; power of 2, minimum 2.
PTR_W, 2, log2(DEPTH).
AFULL_TH, 3, occupancy at or above which pause_x asserts.
SYNC_CNT, 4, consecutive rx_sync cycles needed to enter ACTIVE.
COM, 8'hBC, filler byte driven when valid_out=0.

Ports:
clk_4f  in  1  sole clock; all state updates on posedge.
reset_L  in  1  asynchronous, active-low reset.
data_in_0..data_in_3  in  8 each  lane bytes.
valid_in_0..valid_in_3  in  1 each  write strobe for the lane FIFO.
rx_sync  in  1  high while the receive deserializer is locked.
data_out  out  8  byte to the serializer (registered).
valid_out  out  1  data_out carries a lane byte (registered).
lane_sel  out  2  lane index of the current data_out (registered).
pause_0..pause_3  out  1 each  per-lane almost-full.
overflow_0..overflow_3  out  1 each  sticky drop flag.
state  out  2  link state encoding.

Behaviour:
- Reset (reset_L=0, asynchronous):
  - All FIFOs are empty and all counters are 0.
  - state=RESET(2'b00), data_out=COM, valid_out=0, lane_sel=0.
  - pause_x=0, overflow_x=0.
  - Round-robin pointer last_grant=3, so lane 0 has first priority.
- FSM:
  - RESET -> WAIT_SYNC(2'b01) on the first clock after release.
  - WAIT_SYNC: sync_cnt increments while rx_sync=1 and clears to 0 when rx_sync=0. When sync_cnt reaches SYNC_CNT-1 with rx_sync=1, the FSM goes to ACTIVE(2'b10) and sync_cnt clears.
  - ACTIVE: if rx_sync=0 on any cycle, go to WAIT_SYNC on the same edge. No grant is made on that cycle.
  - 2'b11 is unused and recovers to RESET.
- FIFO write:
  - valid_in_x=1 writes data_in_x on the posedge in WAIT_SYNC and ACTIVE.
  - Writes in RESET are ignored without setting overflow.
  - Each FIFO has a PTR_W-bit read/write pointer that wraps DEPTH-1 -> 0, plus a PTR_W+1-bit count.
- Full boundary:
  - Write to a full FIFO with no same-cycle read: byte dropped, overflow_x set; it clears only on reset.
  - Write to a full FIFO that is granted the same cycle: read and write both occur, count is unchanged, no overflow.
- Empty boundary: simultaneous write and grant is impossible, because grant requires count>0 before the edge. No bypass path.
- pause_x = (count_x >= AFULL_TH), decoded combinationally from the registered count.
- Arbitration (ACTIVE only):
  - Among non-empty lanes, grant the first lane searching from (last_grant+1) mod 4 upward with wrap.
  - On a grant: pop that FIFO, register the byte into data_out, set valid_out=1, lane_sel=lane, last_grant=lane.
  - No grant (not ACTIVE, or all FIFOs empty): data_out=COM, valid_out=0, lane_sel holds, last_grant holds.
- Latency: a byte written into an empty FIFO at edge k (ACTIVE, no competing lanes) appears on data_out after edge k+1.
- Throughput: one byte per clock. With all four lanes backlogged the grant order is strictly 0,1,2,3,0...
- Data leaving WAIT_SYNC is untouched; buffered bytes drain once ACTIVE resumes, in FIFO order.
- Reset asserted mid-operation: buffered bytes are discarded and all outputs return to reset values immediately.

Test Plan:
- Reset, then rx_sync=1 held -> state 00->01, then 10 exactly 4 clocks later; data_out=8'hBC, valid_out=0 throughout.
- In ACTIVE, write 8'h11 to lane 2 only -> next edge data_out=8'h11, valid_out=1, lane_sel=2; following cycle data_out=8'hBC, valid_out=0.
- Preload 2 bytes in every lane (0xA0,0xA1 lane0 ... 0xD0,0xD1 lane3) in WAIT_SYNC, then sync -> output sequence A0,B0,C0,D0,A1,B1,C1,D1, then BC.
- Lane 1 written 5 times in WAIT_SYNC -> pause_1=1 after 3rd write, overflow_1=1 after 5th; after sync exactly the first 4 bytes are output.
- Lane 0 full in ACTIVE with a write on its grant cycle -> no overflow; count stays 4.
- rx_sync dropped in ACTIVE with bytes pending -> state=01, valid_out=0 next edge. Re-sync resumes draining with no byte lost or duplicated. reset_L pulse mid-stream -> all outputs reset asynchronously.
